// File: rtl/fram_seq_pkg.sv
// rtl/fram_seq_pkg.sv - shared state encoding, widths and parameter defaults for the FRAM sequencer
package fram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    PRECHARGE = 2'd2
  } state_t;

  localparam int PRECHARGE_W           = 4;
  localparam int SYNC_STAGES_DEF       = 2;
  localparam int PRECHARGE_CYCLES_DEF  = 3;

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - single-bit N-stage synchronizer with a configurable reset value
module bus_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (!reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fram_access_sequencer.sv
// rtl/fram_access_sequencer.sv - FRAM /CE and /WE sequencer with bank latch and CE-high precharge
// Optional registered, CE-qualified /WE gating is selected by defining FRAM_WE_GATE_EN.
module fram_access_sequencer
  import fram_seq_pkg::*;
#(
  parameter int SYNC_STAGES      = SYNC_STAGES_DEF,
  parameter int PRECHARGE_CYCLES = PRECHARGE_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ramSel,
  input  logic       inputCE,
  input  logic       inputRD,
  input  logic       inputWR,
  input  logic [1:0] ramBankIn,
  output logic       ramCE,
  output logic       ramWE,
  output logic [1:0] ramBankOut,
  output logic       busy
);

  localparam logic [PRECHARGE_W-1:0] PRECHARGE_LOAD = PRECHARGE_W'(PRECHARGE_CYCLES - 1);

  logic ramSel_s;
  logic inputCE_s;
  logic inputRD_s;
  logic inputWR_s;
  logic req;

  state_t                 state;
  state_t                 state_next;
  logic [PRECHARGE_W-1:0] cnt;
  logic [PRECHARGE_W-1:0] cnt_next;

  bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) sync_sel (
    .clock(clock), .reset(reset), .d(ramSel),  .q(ramSel_s)
  );
  bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) sync_ce (
    .clock(clock), .reset(reset), .d(inputCE), .q(inputCE_s)
  );
  bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) sync_rd (
    .clock(clock), .reset(reset), .d(inputRD), .q(inputRD_s)
  );
  bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) sync_wr (
    .clock(clock), .reset(reset), .d(inputWR), .q(inputWR_s)
  );

  assign req = ramSel_s & !inputCE_s & (!inputRD_s | !inputWR_s);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!req) begin
          state_next = PRECHARGE;
          cnt_next   = PRECHARGE_LOAD;
        end
      end
      PRECHARGE: begin
        // A request arriving here stays pending as a level and is taken from IDLE.
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ramCE      <= 1'b1;
      busy       <= 1'b0;
      ramBankOut <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ramCE <= (state_next != ACTIVE);
      busy  <= (state_next != IDLE);
      if (state == IDLE && state_next == ACTIVE) ramBankOut <= ramBankIn;
    end
  end

`ifdef FRAM_WE_GATE_EN
  // State already ACTIVE means CE has been low for at least one clock.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ramWE <= 1'b1;
    end else begin
      ramWE <= !(state == ACTIVE && state_next == ACTIVE && !inputWR_s);
    end
  end
`else
  assign ramWE = inputWR;
`endif

endmodule
